round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 20, clk ticks per second.
REQ-002 Parameter COUNTDOWN_TICKS, default 60, pre-fight countdown length; SHALL be ≤ 3*TICKS_PER_SEC.
REQ-003 Parameter RESULT_TICKS, default 40, round-result display length.
REQ-004 Parameter HOLD_TICKS, default 40, consecutive-hold length for restart inputs.
REQ-005 clk  in  1  20 Hz game tick clock (CLK_20Hz domain); single clock.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 winner  in  3  round result from health management: 0 fighting, 1 P1 won, 2 P2 won, 3 draw, 4-7 treated as 0.
REQ-008 confirm_btn  in  1  restart request (btnC), honoured only in MATCH_OVER.
REQ-009 force_reset  in  1  restart request (sw[0]), honoured in any state.
REQ-010 round_reset  out  1  reset level to physics, collision, health blocks.
REQ-011 freeze  out  1  high = player movement/attack inputs shall be ignored downstream.
REQ-012 round_num  out  2  current round, 1..3.
REQ-013 score_p1, score_p2  out  2 each  rounds won, 0..2.
REQ-014 match_winner  out  2  0 none, 1 P1, 2 P2, 3 draw.
REQ-015 countdown  out  2  displayed digit 3..1 during COUNTDOWN, else 0.
REQ-016 state  out  3  encoded FSM state for menu/7-seg display.

Function
REQ-017 States: RESET_ROUND=0, COUNTDOWN=1, FIGHT=2, ROUND_OVER=3, MATCH_OVER=4; all other encodings SHALL go to RESET_ROUND next cycle.
REQ-018 RESET_ROUND: round_reset=1, freeze=1, lasts exactly 1 cycle, then COUNTDOWN with timer loaded COUNTDOWN_TICKS-1.
REQ-019 COUNTDOWN: freeze=1, round_reset=0, winner ignored; timer decrements each cycle; countdown = timer/TICKS_PER_SEC + 1; at timer==0 go FIGHT next cycle.
REQ-020 FIGHT: freeze=0; first cycle winner∈{1,2,3} is captured once: 1 → score_p1+1, 2 → score_p2+1, 3 → no score; go ROUND_OVER, timer loaded RESULT_TICKS-1.
REQ-021 ROUND_OVER: freeze=1, winner ignored; timer decrements; at timer==0 decide next state per REQ-022..024.
REQ-022 Either score ==2 → MATCH_OVER, match_winner = that player.
REQ-023 Else round_num==3 → MATCH_OVER, match_winner = higher score, 3 if equal.
REQ-024 Else round_num+1, go RESET_ROUND.
REQ-025 Scores saturate at 2; round_num saturates at 3; no wrap-around.
REQ-026 MATCH_OVER: freeze=1, round_reset=0, scores/match_winner held until restart.
REQ-027 Hold counter counts consecutive cycles of hold_src = force_reset | (confirm_btn & state==MATCH_OVER); clears to 0 on any cycle hold_src=0; saturates at HOLD_TICKS.
REQ-028 Restart fires on the cycle the counter transitions HOLD_TICKS-1 → HOLD_TICKS: scores=0, match_winner=0, round_num=1, next state RESET_ROUND; fires once per press (release required to re-fire).
REQ-029 Restart has priority over all FSM transitions, including a winner capture in the same cycle (capture discarded).
REQ-030 Restart mid-COUNTDOWN/FIGHT/ROUND_OVER SHALL abort the round with no score change.
REQ-031 freeze, round_reset, countdown SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-032 reset_n=0 at a clk edge: state=RESET_ROUND, round_reset=1, freeze=1, round_num=1, scores=0, match_winner=0, countdown=0, timers and hold counter=0.
REQ-033 First cycle after reset_n release behaves as RESET_ROUND (REQ-018).
REQ-034 reset_n overrides restart and all other inputs.

Verification
REQ-035 Reset release, winner=0 → round_reset high 1 cycle; countdown 3 for 20 cycles, 2 for 20, 1 for 20; freeze falls on cycle 62 after release.
REQ-036 In FIGHT, winner=1 for 1 cycle then 0, twice across rounds → score_p1=1 then 2; after second RESULT_TICKS, state=4, match_winner=1, round_num=2.
REQ-037 Rounds: P1 win, P2 win, draw → round_num=3, match_winner=3, scores 1/1.
REQ-038 MATCH_OVER, confirm_btn high 39 cycles, low 1, high 40 → restart only at 40th cycle of second hold; scores 0, round_num 1, round_reset pulse.
REQ-039 FIGHT, force_reset held 40 cycles with winner=2 on cycle 40 → restart, score_p2 stays 0; holding further 100 cycles → no second restart.
REQ-040 reset_n low for 1 cycle mid-ROUND_OVER with score_p1=1 → all outputs return to REQ-032 values next cycle.

Source files
------------

// File: rtl/round_controller_if.sv
// round_controller_if
// Groups the game-side signals of the round controller.
//   winner        : round result from health management (0 fighting, 1 P1, 2 P2, 3 draw)
//   confirm_btn   : restart request, honoured only once the match is over
//   force_reset   : restart request, honoured in any state
//   round_reset   : reset level to the physics/collision/health blocks
//   freeze        : high while player inputs are to be ignored
//   round_num     : current round, 1..3
//   score_p1/p2   : rounds won per player, 0..2
//   match_winner  : 0 none, 1 P1, 2 P2, 3 draw
//   countdown     : displayed countdown digit, 0 outside the countdown
//   state         : encoded controller state for menu/7-seg display
// The slave modport is the controller side; master is the surrounding game.
interface round_controller_if;
  logic [2:0] winner;
  logic       confirm_btn;
  logic       force_reset;
  logic       round_reset;
  logic       freeze;
  logic [1:0] round_num;
  logic [1:0] score_p1;
  logic [1:0] score_p2;
  logic [1:0] match_winner;
  logic [1:0] countdown;
  logic [2:0] state;

  modport master (
    output winner, confirm_btn, force_reset,
    input  round_reset, freeze, round_num, score_p1, score_p2,
           match_winner, countdown, state
  );

  modport slave (
    input  winner, confirm_btn, force_reset,
    output round_reset, freeze, round_num, score_p1, score_p2,
           match_winner, countdown, state
  );
endinterface

// File: rtl/round_controller.sv
// round_controller
// Sequences a best-of-three fighting match: per-round reset pulse, pre-fight
// countdown, fight, result display, and match-over hold, with a held-button
// restart that can abort any phase.
// Ports:
//   clk      : game tick clock
//   reset_n  : synchronous active-low reset
//   bus      : round_controller_if.slave (winner/restart inputs, status outputs)
//
// state          | meaning
// ---------------+--------------------------------------------------------
// 0 RESET_ROUND  | one-cycle round reset pulse to the game blocks
// 1 COUNTDOWN    | players frozen, countdown digit 3..1 shown
// 2 FIGHT        | players free, waiting for a round result
// 3 ROUND_OVER   | result displayed, players frozen
// 4 MATCH_OVER   | final scores held until restart
module round_controller #(
  parameter int TICKS_PER_SEC   = 20,
  parameter int COUNTDOWN_TICKS = 60,
  parameter int RESULT_TICKS    = 40,
  parameter int HOLD_TICKS      = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  round_controller_if.slave bus
);

  localparam logic [2:0] S_RESET_ROUND = 3'd0;
  localparam logic [2:0] S_COUNTDOWN   = 3'd1;
  localparam logic [2:0] S_FIGHT       = 3'd2;
  localparam logic [2:0] S_ROUND_OVER  = 3'd3;
  localparam logic [2:0] S_MATCH_OVER  = 3'd4;

  // The timer only ever holds a load value (ticks-1), so clog2 of the larger
  // duration is wide enough.
  localparam int TIMER_MAX = (COUNTDOWN_TICKS > RESULT_TICKS) ? COUNTDOWN_TICKS : RESULT_TICKS;
  localparam int TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam int HOLD_W    = $clog2(HOLD_TICKS + 1);

  localparam logic [TIMER_W-1:0] CD_LOAD   = TIMER_W'(COUNTDOWN_TICKS - 1);
  localparam logic [TIMER_W-1:0] RES_LOAD  = TIMER_W'(RESULT_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_FIRE = HOLD_W'(HOLD_TICKS - 1);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [1:0]         round_num_q, round_num_d;
  logic [1:0]         score_p1_q, score_p1_d;
  logic [1:0]         score_p2_q, score_p2_d;
  logic [1:0]         match_winner_q, match_winner_d;
  logic [1:0]         countdown_q, countdown_d;
  logic               freeze_q, freeze_d;
  logic               round_reset_q, round_reset_d;

  logic hold_src;
  logic restart;

  // Restart hold counter: counts consecutive held cycles, saturates so a
  // long press fires exactly once.
  always_comb begin
    hold_src = bus.force_reset | (bus.confirm_btn & (state_q == S_MATCH_OVER));
    hold_d   = '0;
    if (hold_src) begin
      if (hold_q == HOLD_MAX) hold_d = hold_q;
      else                    hold_d = hold_q + 1'b1;
    end
    restart = hold_src && (hold_q == HOLD_FIRE);
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    round_num_d    = round_num_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    match_winner_d = match_winner_q;

    case (state_q)
      S_RESET_ROUND: begin
        state_d = S_COUNTDOWN;
        timer_d = CD_LOAD;
      end

      S_COUNTDOWN: begin
        if (timer_q == '0) state_d = S_FIGHT;
        else               timer_d = timer_q - 1'b1;
      end

      S_FIGHT: begin
        // Results 4..7 are treated as still fighting.
        case (bus.winner)
          3'd1: begin
            if (score_p1_q != 2'd2) score_p1_d = score_p1_q + 2'd1;
            state_d = S_ROUND_OVER;
            timer_d = RES_LOAD;
          end
          3'd2: begin
            if (score_p2_q != 2'd2) score_p2_d = score_p2_q + 2'd1;
            state_d = S_ROUND_OVER;
            timer_d = RES_LOAD;
          end
          3'd3: begin
            state_d = S_ROUND_OVER;
            timer_d = RES_LOAD;
          end
          default: ;
        endcase
      end

      S_ROUND_OVER: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (score_p1_q == 2'd2) begin
          state_d        = S_MATCH_OVER;
          match_winner_d = 2'd1;
        end else if (score_p2_q == 2'd2) begin
          state_d        = S_MATCH_OVER;
          match_winner_d = 2'd2;
        end else if (round_num_q == 2'd3) begin
          state_d = S_MATCH_OVER;
          if (score_p1_q > score_p2_q)      match_winner_d = 2'd1;
          else if (score_p2_q > score_p1_q) match_winner_d = 2'd2;
          else                              match_winner_d = 2'd3;
        end else begin
          round_num_d = round_num_q + 2'd1;
          state_d     = S_RESET_ROUND;
        end
      end

      S_MATCH_OVER: ;

      default: begin
        state_d = S_RESET_ROUND;
        timer_d = '0;
      end
    endcase

    // Restart wins over everything above, including a same-cycle capture.
    if (restart) begin
      state_d        = S_RESET_ROUND;
      timer_d        = '0;
      round_num_d    = 2'd1;
      score_p1_d     = 2'd0;
      score_p2_d     = 2'd0;
      match_winner_d = 2'd0;
    end

    // Status outputs are decoded from the next state so they register
    // in step with it.
    freeze_d      = (state_d != S_FIGHT);
    round_reset_d = (state_d == S_RESET_ROUND);
    countdown_d   = 2'd0;
    if (state_d == S_COUNTDOWN)
      countdown_d = 2'((32'(timer_d) / TICKS_PER_SEC) + 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_RESET_ROUND;
      timer_q        <= '0;
      hold_q         <= '0;
      round_num_q    <= 2'd1;
      score_p1_q     <= 2'd0;
      score_p2_q     <= 2'd0;
      match_winner_q <= 2'd0;
      countdown_q    <= 2'd0;
      freeze_q       <= 1'b1;
      round_reset_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      round_num_q    <= round_num_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      match_winner_q <= match_winner_d;
      countdown_q    <= countdown_d;
      freeze_q       <= freeze_d;
      round_reset_q  <= round_reset_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.round_num    = round_num_q;
  assign bus.score_p1     = score_p1_q;
  assign bus.score_p2     = score_p2_q;
  assign bus.match_winner = match_winner_q;
  assign bus.countdown    = countdown_q;
  assign bus.freeze       = freeze_q;
  assign bus.round_reset  = round_reset_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller
// Drives round_controller through reset, full matches, button and switch
// restarts, and a mid-round reset. Round and match results are predicted
// when the winner stimulus is applied and compared when the controller
// enters ROUND_OVER or MATCH_OVER.
module tb_round_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int st;
    int p1;
    int p2;
    int rn;
    int mw;
  } exp_t;

  exp_t sb_q[$];

  round_controller_if bus ();

  round_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string tag, output int cyc);
    cyc = 0;
    while (int'(bus.state) != s && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (int'(bus.state) != s) chk(tag, int'(bus.state), s);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, bus.state, 0);
    chk({pfx, "_rr"},    bus.round_reset, 1);
    chk({pfx, "_frz"},   bus.freeze, 1);
    chk({pfx, "_rn"},    bus.round_num, 1);
    chk({pfx, "_p1"},    bus.score_p1, 0);
    chk({pfx, "_p2"},    bus.score_p2, 0);
    chk({pfx, "_mw"},    bus.match_winner, 0);
    chk({pfx, "_cd"},    bus.countdown, 0);
  endtask

  task automatic win_pulse(input logic [2:0] w);
    bus.winner = w;
    tick(1);
    bus.winner = 3'd0;
  endtask

  // Scoreboard monitor: pops one prediction per entry into ROUND_OVER/MATCH_OVER.
  logic [2:0] prev_st;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_st <= 3'd0;
    end else begin
      if (bus.state != prev_st && (bus.state == 3'd3 || bus.state == 3'd4)) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_state", int'(bus.state), 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_state", bus.state, e.st);
          chk("sb_p1", bus.score_p1, e.p1);
          chk("sb_p2", bus.score_p2, e.p2);
          chk("sb_rn", bus.round_num, e.rn);
          chk("sb_mw", bus.match_winner, e.mw);
        end
      end
      prev_st <= bus.state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rr_cnt;
    int exp_cd;

    reset_n         = 1'b0;
    bus.winner      = 3'd0;
    bus.confirm_btn = 1'b0;
    bus.force_reset = 1'b0;
    tick(3);
    chk_reset_vals("rst");

    // Reset release: one reset cycle, 20 cycles each of 3/2/1, fight on 62.
    reset_n = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      if (c == 1 || c == 62) exp_cd = 0;
      else if (c <= 21)      exp_cd = 3;
      else if (c <= 41)      exp_cd = 2;
      else                   exp_cd = 1;
      chk($sformatf("cd_c%0d", c), bus.countdown, exp_cd);
      chk($sformatf("rr_c%0d", c), bus.round_reset, (c == 1) ? 1 : 0);
      chk($sformatf("frz_c%0d", c), bus.freeze, (c < 62) ? 1 : 0);
      if (c < 62) tick(1);
    end
    chk("fight_state", bus.state, 2);

    // P1 wins two rounds.
    sb_q.push_back('{3, 1, 0, 1, 0});
    win_pulse(3'd1);
    wait_state(2, 200, "to_fight_r2", cyc);
    sb_q.push_back('{3, 2, 0, 2, 0});
    sb_q.push_back('{4, 2, 0, 2, 1});
    win_pulse(3'd1);
    wait_state(4, 100, "to_match_over", cyc);
    chk("result_len", cyc, 40);
    chk("mo_frz", bus.freeze, 1);
    chk("mo_cd", bus.countdown, 0);

    // Confirm held 39, released 1, held 40: only the second hold restarts.
    bus.confirm_btn = 1'b1;
    tick(39);
    chk("hold39_state", bus.state, 4);
    bus.confirm_btn = 1'b0;
    tick(1);
    bus.confirm_btn = 1'b1;
    tick(39);
    chk("hold2_39_state", bus.state, 4);
    chk("hold2_39_p1", bus.score_p1, 2);
    tick(1);
    bus.confirm_btn = 1'b0;
    chk_reset_vals("confirm_rst");

    // P1 win, P2 win, draw: draw match after round 3.
    wait_state(2, 100, "to_fight_d1", cyc);
    sb_q.push_back('{3, 1, 0, 1, 0});
    win_pulse(3'd1);
    wait_state(2, 200, "to_fight_d2", cyc);
    sb_q.push_back('{3, 1, 1, 2, 0});
    win_pulse(3'd2);
    wait_state(2, 200, "to_fight_d3", cyc);
    sb_q.push_back('{3, 1, 1, 3, 0});
    sb_q.push_back('{4, 1, 1, 3, 3});
    win_pulse(3'd3);
    wait_state(4, 100, "to_match_over_d", cyc);

    // Switch restart from MATCH_OVER.
    bus.force_reset = 1'b1;
    tick(40);
    bus.force_reset = 1'b0;
    chk_reset_vals("force_mo");

    // Switch restart in FIGHT beats a same-cycle P2 win.
    wait_state(2, 100, "to_fight_f", cyc);
    bus.force_reset = 1'b1;
    tick(39);
    chk("force39_state", bus.state, 2);
    bus.winner = 3'd2;
    tick(1);
    bus.winner = 3'd0;
    chk("force_state", bus.state, 0);
    chk("force_p2", bus.score_p2, 0);
    chk("force_rr", bus.round_reset, 1);
    rr_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bus.round_reset) rr_cnt++;
    end
    bus.force_reset = 1'b0;
    chk("force_refire", rr_cnt, 0);
    chk("force_after_state", bus.state, 2);
    chk("force_after_p2", bus.score_p2, 0);

    // Reset pulse during ROUND_OVER with a point on the board.
    sb_q.push_back('{3, 1, 0, 1, 0});
    win_pulse(3'd1);
    tick(5);
    chk("ro_state", bus.state, 3);
    chk("ro_p1", bus.score_p1, 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk_reset_vals("mid_rst");

    tick(2);
    chk("sb_left", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
